ram_nw_mr: RTL and testbench

//  Parametrised multi-port RAM: NW write ports, NR read ports, synchronous read with full forwarding.

---
 rtl/ram_nw_mr_pkg.sv | 13 +
 rtl/ram_nw_mr_fwd_sel.sv | 42 ++++
 rtl/ram_nw_mr.sv | 96 +++++++++
 tb/tb_ram_nw_mr.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_nw_mr_pkg.sv
// Shared definitions for the multi-port RAM: read-during-write mode encodings and a
// sizing helper used by the top level.
package ram_nw_mr_pkg;

    // Encodings for the WRITE_FIRST parameter
    localparam int unsigned RdwOld = 0;
    localparam int unsigned RdwNew = 1;

    function automatic int unsigned ram_lines(input int unsigned deepth);
        return 32'd1 << deepth;
    endfunction

endpackage

// File: rtl/ram_nw_mr_fwd_sel.sv
// Priority forward mux for one read port: current-cycle writes (optional), then the
// pending write stage, then the array word.
module ram_nw_mr_fwd_sel
    import ram_nw_mr_pkg::*;
#(
    parameter int unsigned DEEPTH      = 8,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NW          = 2,
    parameter int unsigned WRITE_FIRST = RdwNew
) (
    input  logic [DEEPTH-1:0]    read_addr,
    input  logic [NW*DEEPTH-1:0] write_addr,
    input  logic [NW*WIDTH-1:0]  write_data,
    input  logic [NW-1:0]        write_en,
    input  logic [NW*DEEPTH-1:0] pend_addr,
    input  logic [NW*WIDTH-1:0]  pend_data,
    input  logic [NW-1:0]        pend_v,
    input  logic [WIDTH-1:0]     array_word,
    output logic [WIDTH-1:0]     sel_word
);

    localparam bit FwdCur = (WRITE_FIRST != RdwOld);

    // Later assignments override earlier ones, so each loop runs from the highest
    // index down, leaving the lowest-index hit as the final value.
    always_comb begin
        sel_word = array_word;
        for (int k = int'(NW) - 1; k >= 0; k--) begin
            if (pend_v[k] && (pend_addr[k*DEEPTH +: DEEPTH] == read_addr)) begin
                sel_word = pend_data[k*WIDTH +: WIDTH];
            end
        end
        if (FwdCur) begin
            for (int k = int'(NW) - 1; k >= 0; k--) begin
                if (write_en[k] && (write_addr[k*DEEPTH +: DEEPTH] == read_addr)) begin
                    sel_word = write_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

endmodule

// File: rtl/ram_nw_mr.sv
// NW-write / NR-read RAM with a one-deep pending write stage, full read forwarding and
// registered read outputs. Array contents are never reset.
module ram_nw_mr
    import ram_nw_mr_pkg::*;
#(
    parameter int unsigned DEEPTH      = 8,
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NW          = 2,
    parameter int unsigned NR          = 2,
    parameter int unsigned WRITE_FIRST = RdwNew
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic [NW*DEEPTH-1:0] write_addr,
    input  logic [NW*WIDTH-1:0]  write_data,
    input  logic [NW-1:0]        write_EN,
    input  logic [NR*DEEPTH-1:0] read_addr,
    input  logic [NR-1:0]        read_EN,
    output logic [NR*WIDTH-1:0]  read_data
);

    localparam int unsigned LINES = ram_lines(DEEPTH);

    logic [WIDTH-1:0]     mem [LINES];
    logic [NW*DEEPTH-1:0] pend_addr_q;
    logic [NW*WIDTH-1:0]  pend_data_q;
    logic [NW-1:0]        pend_v_q;
    logic [NW-1:0]        pend_v_d;

    // A port loses outright when any lower-index enabled port targets the same address,
    // so the pending stage never holds two entries for one address.
    always_comb begin
        pend_v_d = write_EN;
        for (int k = 1; k < int'(NW); k++) begin
            for (int j = 0; j < k; j++) begin
                if (write_EN[j] &&
                    (write_addr[j*DEEPTH +: DEEPTH] == write_addr[k*DEEPTH +: DEEPTH])) begin
                    pend_v_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            pend_v_q    <= '0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_addr_q <= write_addr;
            pend_data_q <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(NW); k++) begin
            if (pend_v_q[k]) begin
                mem[pend_addr_q[k*DEEPTH +: DEEPTH]] <= pend_data_q[k*WIDTH +: WIDTH];
            end
        end
    end

    for (genvar j = 0; j < NR; j++) begin : g_rd
        logic [WIDTH-1:0] fwd_word;
        logic [WIDTH-1:0] rd_q;

        ram_nw_mr_fwd_sel #(
            .DEEPTH      (DEEPTH),
            .WIDTH       (WIDTH),
            .NW          (NW),
            .WRITE_FIRST (WRITE_FIRST)
        ) u_fwd_sel (
            .read_addr  (read_addr[j*DEEPTH +: DEEPTH]),
            .write_addr (write_addr),
            .write_data (write_data),
            .write_en   (write_EN),
            .pend_addr  (pend_addr_q),
            .pend_data  (pend_data_q),
            .pend_v     (pend_v_q),
            .array_word (mem[read_addr[j*DEEPTH +: DEEPTH]]),
            .sel_word   (fwd_word)
        );

        always_ff @(posedge clk or negedge clrn) begin
            if (!clrn) begin
                rd_q <= '0;
            end else if (read_EN[j]) begin
                rd_q <= fwd_word;
            end
        end

        assign read_data[j*WIDTH +: WIDTH] = rd_q;
    end

endmodule

// File: tb/tb_ram_nw_mr.sv
// Self-checking bench for ram_nw_mr: directed vector table, model-checked random traffic,
// NW/NR sweeps and an asynchronous reset in the middle of a write.
module tb_ram_nw_mr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        clrn;
    logic [15:0] w_addr, w_data, r_addr, rd_new, rd_old;
    logic [1:0]  w_en, r_en;
    logic [7:0]  s_waddr, s_wdata, s_raddr, s_rd;
    logic [0:0]  s_wen, s_ren;
    logic [31:0] b_waddr, b_wdata, b_raddr, b_rd;
    logic [3:0]  b_wen, b_ren;

    int checks = 0;
    int failures = 0;

    // Architectural model: writes land instantly, lower port index wins
    logic [7:0] m_mem [256];
    logic [7:0] m_rd_new [2];
    logic [7:0] m_rd_old [2];

    ram_nw_mr #(.DEEPTH(8), .WIDTH(8), .NW(2), .NR(2), .WRITE_FIRST(1)) u_new (
        .clk(clk), .clrn(clrn), .write_addr(w_addr), .write_data(w_data), .write_EN(w_en),
        .read_addr(r_addr), .read_EN(r_en), .read_data(rd_new)
    );
    ram_nw_mr #(.DEEPTH(8), .WIDTH(8), .NW(2), .NR(2), .WRITE_FIRST(0)) u_old (
        .clk(clk), .clrn(clrn), .write_addr(w_addr), .write_data(w_data), .write_EN(w_en),
        .read_addr(r_addr), .read_EN(r_en), .read_data(rd_old)
    );
    ram_nw_mr #(.DEEPTH(8), .WIDTH(8), .NW(1), .NR(1), .WRITE_FIRST(1)) u_small (
        .clk(clk), .clrn(clrn), .write_addr(s_waddr), .write_data(s_wdata), .write_EN(s_wen),
        .read_addr(s_raddr), .read_EN(s_ren), .read_data(s_rd)
    );
    ram_nw_mr #(.DEEPTH(8), .WIDTH(8), .NW(4), .NR(4), .WRITE_FIRST(1)) u_big (
        .clk(clk), .clrn(clrn), .write_addr(b_waddr), .write_data(b_wdata), .write_EN(b_wen),
        .read_addr(b_raddr), .read_EN(b_ren), .read_data(b_rd)
    );

    typedef struct {
        logic [1:0] we;
        logic [7:0] wa0, wd0, wa1, wd1;
        logic [1:0] re;
        logic [7:0] ra0, ra1;
        logic [1:0] chk;
        logic [7:0] e0, e1;
        bit         cko;
        logic [7:0] eo0;
    } vec_t;

    vec_t vt [16];

    function automatic vec_t mk(input logic [1:0] we, input logic [7:0] wa0, input logic [7:0] wd0,
                                input logic [7:0] wa1, input logic [7:0] wd1,
                                input logic [1:0] re, input logic [7:0] ra0, input logic [7:0] ra1,
                                input logic [1:0] chk, input logic [7:0] e0, input logic [7:0] e1,
                                input bit cko, input logic [7:0] eo0);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.re = re; v.ra0 = ra0; v.ra1 = ra1;
        v.chk = chk; v.e0 = e0; v.e1 = e1; v.cko = cko; v.eo0 = eo0;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        w_en = '0; r_en = '0; s_wen = '0; s_ren = '0; b_wen = '0; b_ren = '0;
    endtask

    // One clock: inputs already driven; update the model at the edge, return at negedge
    task automatic cycle();
        @(posedge clk);
        for (int j = 0; j < 2; j++) if (r_en[j]) m_rd_old[j] = m_mem[r_addr[j*8 +: 8]];
        for (int k = 1; k >= 0; k--) if (w_en[k]) m_mem[w_addr[k*8 +: 8]] = w_data[k*8 +: 8];
        for (int j = 0; j < 2; j++) if (r_en[j]) m_rd_new[j] = m_mem[r_addr[j*8 +: 8]];
        @(negedge clk);
    endtask

    logic [7:0] prev_wa0;

    initial begin
        clrn = 1'b1;
        w_addr = '0; w_data = '0; r_addr = '0;
        s_waddr = '0; s_wdata = '0; s_raddr = '0;
        b_waddr = '0; b_wdata = '0; b_raddr = '0;
        idle();
        #2 clrn = 1'b0;
        #1;
        check("reset_rd_new", {16'h0, rd_new}, 32'h0);
        check("reset_rd_old", {16'h0, rd_old}, 32'h0);
        check("reset_small", {24'h0, s_rd}, 32'h0);
        check("reset_big", b_rd, 32'h0);
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;

        //         we     wa0    wd0    wa1    wd1    re     ra0    ra1    chk    e0     e1    cko eo0
        vt[0]  = mk(2'b01, 8'h3C, 8'h11, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 0, 8'h00);
        vt[1]  = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 0, 8'h00);
        vt[2]  = mk(2'b01, 8'h3C, 8'hA5, 8'h00, 8'h00, 2'b01, 8'h3C, 8'h00, 2'b01, 8'hA5, 8'h00, 1, 8'h11);
        vt[3]  = mk(2'b01, 8'h05, 8'h11, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 2'b00, 8'h00, 8'h00, 0, 8'h00);
        vt[4]  = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 8'h11, 8'h00, 1, 8'h11);
        vt[5]  = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b01, 8'h05, 8'h00, 2'b01, 8'h11, 8'h00, 1, 8'h11);
        vt[6]  = mk(2'b11, 8'h7E, 8'h01, 8'h7E, 8'h02, 2'b11, 8'h7E, 8'h7E, 2'b11, 8'h01, 8'h01, 0, 8'h00);
        vt[7]  = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h7E, 8'h7E, 2'b11, 8'h01, 8'h01, 1, 8'h01);
        vt[8]  = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h7E, 8'h7E, 2'b11, 8'h01, 8'h01, 1, 8'h01);
        vt[9]  = mk(2'b01, 8'h20, 8'h55, 8'h00, 8'h00, 2'b11, 8'h20, 8'h20, 2'b11, 8'h55, 8'h55, 0, 8'h00);
        vt[10] = mk(2'b10, 8'h00, 8'h00, 8'h20, 8'h66, 2'b11, 8'h20, 8'h20, 2'b11, 8'h66, 8'h66, 1, 8'h55);
        vt[11] = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h20, 8'h20, 2'b11, 8'h66, 8'h66, 1, 8'h66);
        vt[12] = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h20, 8'h20, 2'b11, 8'h66, 8'h66, 1, 8'h66);
        vt[13] = mk(2'b01, 8'h20, 8'h77, 8'h00, 8'h00, 2'b00, 8'h20, 8'h20, 2'b11, 8'h66, 8'h66, 1, 8'h66);
        vt[14] = mk(2'b11, 8'h00, 8'hC3, 8'hFF, 8'h3C, 2'b11, 8'hFF, 8'h00, 2'b11, 8'h3C, 8'hC3, 0, 8'h00);
        vt[15] = mk(2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b11, 8'h00, 8'hFF, 2'b11, 8'hC3, 8'h3C, 1, 8'hC3);

        for (int i = 0; i < 16; i++) begin
            w_en = vt[i].we; w_addr = {vt[i].wa1, vt[i].wa0}; w_data = {vt[i].wd1, vt[i].wd0};
            r_en = vt[i].re; r_addr = {vt[i].ra1, vt[i].ra0};
            cycle();
            if (vt[i].chk[0]) check($sformatf("vec%0d_rd0", i), {24'h0, rd_new[7:0]}, {24'h0, vt[i].e0});
            if (vt[i].chk[1]) check($sformatf("vec%0d_rd1", i), {24'h0, rd_new[15:8]}, {24'h0, vt[i].e1});
            if (vt[i].cko) check($sformatf("vec%0d_old0", i), {24'h0, rd_old[7:0]}, {24'h0, vt[i].eo0});
        end

        // Random parallel traffic over a 16-entry window, checked against the model
        for (int i = 0; i < 8; i++) begin
            w_en = 2'b11; r_en = 2'b00;
            w_addr = {8'h80 | 8'(2*i+1), 8'h80 | 8'(2*i)};
            w_data = {8'($urandom), 8'($urandom)};
            cycle();
        end
        idle();
        cycle();
        prev_wa0 = 8'h80;
        for (int i = 0; i < 40; i++) begin
            w_en = 2'($urandom);
            w_addr = {8'h80 | 8'($urandom_range(15)), 8'h80 | 8'($urandom_range(15))};
            w_data = {8'($urandom), 8'($urandom)};
            r_en = 2'($urandom);
            r_addr = {8'h80 | 8'($urandom_range(15)), prev_wa0};
            cycle();
            prev_wa0 = w_addr[7:0];
            check($sformatf("rand%0d_new0", i), {24'h0, rd_new[7:0]}, {24'h0, m_rd_new[0]});
            check($sformatf("rand%0d_new1", i), {24'h0, rd_new[15:8]}, {24'h0, m_rd_new[1]});
            check($sformatf("rand%0d_old0", i), {24'h0, rd_old[7:0]}, {24'h0, m_rd_old[0]});
            check($sformatf("rand%0d_old1", i), {24'h0, rd_old[15:8]}, {24'h0, m_rd_old[1]});
        end
        idle();

        // NW=1 / NR=1
        s_wen = 1'b1; s_waddr = 8'h42; s_wdata = 8'h5A; s_ren = 1'b1; s_raddr = 8'h42;
        cycle(); check("small_cur", {24'h0, s_rd}, 32'h5A);
        s_waddr = 8'h43; s_wdata = 8'hA5; s_raddr = 8'h42;
        cycle(); check("small_pend", {24'h0, s_rd}, 32'h5A);
        s_wen = 1'b0; s_raddr = 8'h43;
        cycle(); check("small_pend2", {24'h0, s_rd}, 32'hA5);
        s_raddr = 8'h42;
        cycle(); check("small_array", {24'h0, s_rd}, 32'h5A);
        s_ren = 1'b0; s_raddr = 8'h43;
        cycle(); check("small_hold", {24'h0, s_rd}, 32'h5A);

        // NW=4 / NR=4
        b_wen = 4'hF; b_waddr = 32'h33333333; b_wdata = 32'h04030201;
        b_ren = 4'hF; b_raddr = 32'h33333333;
        cycle(); check("big_conflict", b_rd, 32'h01010101);
        b_waddr = 32'h43424140; b_wdata = 32'h13121110; b_raddr = 32'h40414243;
        cycle(); check("big_cross", b_rd, 32'h10111213);
        b_wen = 4'h0; b_ren = 4'b0111; b_raddr = 32'h33404333;
        cycle(); check("big_mix_hold", b_rd, 32'h10101301);
        b_wen = 4'b1100; b_waddr = 32'h50500000; b_wdata = 32'hBBAA0000;
        b_ren = 4'b0001; b_raddr = 32'h00000050;
        cycle(); check("big_hi_conflict", b_rd, 32'h101013AA);
        b_wen = 4'h0; b_ren = 4'b0010; b_raddr = 32'h00005000;
        cycle(); check("big_hi_pend", b_rd, 32'h1010AAAA);
        b_ren = 4'b0100; b_raddr = 32'h00500000;
        cycle(); check("big_hi_array", b_rd, 32'h10AAAAAA);
        idle();

        // Reset in the middle of a write: 0x10 committed, 0x11 still pending
        w_en = 2'b01; w_addr = 16'h0011; w_data = 16'h0044;
        s_wen = 1'b1; s_waddr = 8'h11; s_wdata = 8'h44;
        b_wen = 4'b0001; b_waddr = 32'h11; b_wdata = 32'h44;
        cycle();
        idle();
        cycle();
        w_en = 2'b01; w_addr = 16'h0010; w_data = 16'h0099;
        s_wen = 1'b1; s_waddr = 8'h10; s_wdata = 8'h99;
        b_wen = 4'b0001; b_waddr = 32'h10; b_wdata = 32'h99;
        cycle();
        w_addr = 16'h0011; w_data = 16'h0077; r_en = 2'b01; r_addr = 16'h0010;
        s_waddr = 8'h11; s_wdata = 8'h77; s_ren = 1'b1; s_raddr = 8'h10;
        b_waddr = 32'h11; b_wdata = 32'h77; b_ren = 4'b0001; b_raddr = 32'h10;
        @(posedge clk);
        #2 clrn = 1'b0;
        #1;
        check("rst_mid_new", {16'h0, rd_new}, 32'h0);
        check("rst_mid_old", {16'h0, rd_old}, 32'h0);
        check("rst_mid_small", {24'h0, s_rd}, 32'h0);
        check("rst_mid_big", b_rd, 32'h0);
        idle();
        @(negedge clk);
        @(negedge clk);
        clrn = 1'b1;
        r_en = 2'b11; r_addr = 16'h1110;
        s_ren = 1'b1; s_raddr = 8'h10;
        b_ren = 4'b0011; b_raddr = 32'h00001110;
        cycle();
        check("rst_after_new", {16'h0, rd_new}, 32'h4499);
        check("rst_after_old", {16'h0, rd_old}, 32'h4499);
        check("rst_after_small10", {24'h0, s_rd}, 32'h99);
        check("rst_after_big", b_rd, 32'h00004499);
        idle();
        s_ren = 1'b1; s_raddr = 8'h11;
        cycle();
        check("rst_after_small11", {24'h0, s_rd}, 32'h44);
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
